// File: rtl/demux3_stage_pkg.sv
// Shared destination encoding for the 1-to-3 demux stage and the 3-way select drivers.
// The encoding is fixed because both sides rely on the same code for each destination.
package demux3_stage_pkg;

    typedef enum logic [1:0] {
        DEST0    = 2'b00,
        DEST1    = 2'b01,
        DEST2    = 2'b10,
        DEST_BAD = 2'b11
    } dest_e;

    localparam int NUM_DEST = 3;

    function automatic logic is_legal(input logic [1:0] sel);
        return sel != DEST_BAD;
    endfunction

endpackage

// File: rtl/demux3_stage.sv
// Registered 1-to-3 demultiplexer with a single output register and full-throughput handshake.
// Beats with an illegal destination are consumed, dropped, pulsed on drop_o and counted.
module demux3_stage
    import demux3_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            sel_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid0_o,
    output logic                  valid1_o,
    output logic                  valid2_o,
    input  logic                  ready0_i,
    input  logic                  ready1_i,
    input  logic                  ready2_i,
    output logic                  drop_o,
    output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]            state_reg, state_next;
    dest_e                 dest_reg, dest_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  drop_reg, drop_next;
    logic [CNT_WIDTH-1:0]  drop_cnt_reg, drop_cnt_next;

    logic                  full;
    logic                  sel_ready;
    logic                  out_fire;
    logic                  in_fire;
    logic                  legal_fire;
    logic                  bad_fire;
    logic [NUM_DEST-1:0]   valid_vec;

    always_comb begin
        full = (state_reg == ST_FULL);

        // Only the ready of the destination currently holding the beat matters.
        case (dest_reg)
            DEST0:   sel_ready = ready0_i;
            DEST1:   sel_ready = ready1_i;
            DEST2:   sel_ready = ready2_i;
            default: sel_ready = 1'b0;
        endcase

        out_fire   = full && sel_ready;
        ready_o    = !full || out_fire;
        in_fire    = valid_i && ready_o;
        legal_fire = in_fire && is_legal(sel_i);
        bad_fire   = in_fire && !is_legal(sel_i);

        state_next = state_reg;
        dest_next  = dest_reg;
        data_next  = data_reg;
        if (legal_fire) begin
            state_next = ST_FULL;
            dest_next  = dest_e'(sel_i);
            data_next  = data_i;
        end else if (out_fire) begin
            state_next = ST_EMPTY;
        end

        drop_next     = bad_fire;
        drop_cnt_next = drop_cnt_reg;
        if (bad_fire && (drop_cnt_reg != '1)) begin
            drop_cnt_next = drop_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ST_EMPTY;
            dest_reg     <= DEST0;
            data_reg     <= '0;
            drop_reg     <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            dest_reg     <= dest_next;
            data_reg     <= data_next;
            drop_reg     <= drop_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Valids decode straight from registers, so they cannot glitch high during reset.
    for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_valid
        assign valid_vec[gi] = full && (dest_reg == dest_e'(2'(gi)));
    end

    assign valid0_o   = valid_vec[0];
    assign valid1_o   = valid_vec[1];
    assign valid2_o   = valid_vec[2];
    assign data_o     = data_reg;
    assign drop_o     = drop_reg;
    assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: tb/tb_demux3_stage.sv
// Scoreboard bench for demux3_stage: a driver records accepted beats and drops in a model,
// a negedge monitor compares every output against that model.
module tb_demux3_stage;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    sel;
    logic [DW-1:0] data;
    logic          valid;
    logic          r0, r1, r2;

    logic          ready;
    logic [DW-1:0] dout;
    logic          v0, v1, v2;
    logic          drop;
    logic [7:0]    drop_cnt;

    logic          ready_b;
    logic [DW-1:0] dout_b;
    logic          v0_b, v1_b, v2_b;
    logic          drop_b;
    logic [1:0]    drop_cnt_b;

    always #5 clk = ~clk;

    demux3_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .data_i(data), .valid_i(valid),
        .ready_o(ready), .data_o(dout), .valid0_o(v0), .valid1_o(v1), .valid2_o(v2),
        .ready0_i(r0), .ready1_i(r1), .ready2_i(r2), .drop_o(drop), .drop_cnt_o(drop_cnt)
    );

    // Narrow counter instance fed the same stimulus, used to observe saturation.
    demux3_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .data_i(data), .valid_i(valid),
        .ready_o(ready_b), .data_o(dout_b), .valid0_o(v0_b), .valid1_o(v1_b), .valid2_o(v2_b),
        .ready0_i(r0), .ready1_i(r1), .ready2_i(r2), .drop_o(drop_b), .drop_cnt_o(drop_cnt_b)
    );

    typedef struct {
        logic [1:0]    dest;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] exp_last;
    int            drop_total;
    logic          drop_exp;
    int            errors = 0;
    int            checks = 0;
    logic          done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the model says which beat is held, what drop state is due.
    initial begin
        forever begin
            logic [2:0] ev;
            logic [2:0] rv;
            logic       er;
            int         sat8;
            int         sat2;
            @(negedge clk);
            if (!done) begin
                rv = {r2, r1, r0};
                if (exp_q.size() > 0) begin
                    ev = 3'b001 << exp_q[0].dest;
                    er = rv[exp_q[0].dest];
                end else begin
                    ev = 3'b000;
                    er = 1'b1;
                end
                sat8 = (drop_total > 255) ? 255 : drop_total;
                sat2 = (drop_total > 3) ? 3 : drop_total;
                check("valid", 64'({v2, v1, v0}), 64'(ev));
                check("ready", 64'(ready), 64'(er));
                check("data", 64'(dout), 64'(exp_last));
                check("drop", 64'(drop), 64'(drop_exp));
                check("drop_cnt", 64'(drop_cnt), 64'(sat8));
                check("drop_cnt_sat", 64'(drop_cnt_b), 64'(sat2));
                if (exp_q.size() > 0 && er) begin
                    $display("OUT dest=%0d data=%08h", exp_q[0].dest, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] s, input logic [DW-1:0] d,
                        input logic a0, input logic a1, input logic a2);
        logic fire;
        valid = v; sel = s; data = d; r0 = a0; r1 = a1; r2 = a2;
        @(negedge clk);
        fire = valid && ready && rst_n;
        @(posedge clk);
        drop_exp = fire && (s == 2'b11);
        if (fire) begin
            if (s != 2'b11) begin
                exp_q.push_back('{dest: s, data: d});
                exp_last = d;
            end else begin
                drop_total++;
                $display("DROP data=%08h", d);
            end
        end
        #1;
    endtask

    task automatic async_reset();
        valid = 1'b1; sel = 2'b01; data = 32'hABCD0123;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'({v2, v1, v0}), 64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        exp_q.delete();
        exp_last   = '0;
        drop_total = 0;
        drop_exp   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b1; sel = 2'b01; data = 32'hDEADBEEF;
        r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
        exp_last = '0; drop_total = 0; drop_exp = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill toward destination 1, hold, then consume.
        step(1'b1, 2'b01, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);

        // Back-pressure on destination 2; other readies must be ignored.
        step(1'b1, 2'b10, 32'hC0FFEE01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 2'b00, 32'h1111 + i, i[0], ~i[0], 1'b0);
        step(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);

        // Streaming with cycling destinations.
        for (int i = 0; i < 8; i++)
            step(1'b1, 2'(i % 3), 32'h100 + i, 1'b1, 1'b1, 1'b1);
        step(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);

        // Simultaneous in/out without a bubble.
        step(1'b1, 2'b00, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b10, 32'h5, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);

        // Illegal selects, enough to saturate the narrow counter.
        for (int i = 0; i < 5; i++)
            step(1'b1, 2'b11, 32'hBAD0 + i, 1'b1, 1'b1, 1'b1);
        step(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset while a beat is held, then normal traffic.
        step(1'b1, 2'b00, 32'h77, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        async_reset();
        step(1'b1, 2'b01, 32'h88, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);

        // Random traffic with illegal selects and random back-pressure.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
